led_display_ctrl: RTL and testbench

LED_DISPLAY_CTRL -- requirements
Module: led_display_ctrl

---
 rtl/led_display_ctrl.sv | 121 ++++++++++++
 tb/tb_led_display_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/led_display_ctrl.sv
// Eight-digit multiplexed seven-segment driver. A 32-bit word, taken once per frame from one of
// four sources, is scanned one hex digit at a time; outputs are active-low and fully registered.
module led_display_ctrl #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        led_we,
  input  logic [31:0] led_data_in,
  input  logic [31:0] total_cycles,
  input  logic [31:0] condi_branch_num,
  input  logic [31:0] uncondi_branch_num,
  input  logic [1:0]  disp_sel,
  input  logic        freeze,
  output logic [7:0]  an_out,
  output logic [7:0]  seg_out,
  output logic        frame_done
);

  localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    SRC_LED     = 2'd0,
    SRC_CYCLES  = 2'd1,
    SRC_CONDI   = 2'd2,
    SRC_UNCONDI = 2'd3
  } src_e;

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       digit_idx;
  logic [31:0]      led_reg;
  logic [31:0]      snapshot;

  logic        scan_tick;
  logic        frame_wrap;
  logic [31:0] src_word;
  logic [3:0]  nibble;
  logic [7:0]  seg_code;

  assign scan_tick  = (div_cnt == DIV_LAST);
  assign frame_wrap = scan_tick && (digit_idx == 3'd7);
  assign nibble     = snapshot[{digit_idx, 2'b00} +: 4];

  // NOTE: every signal assigned in an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    src_word = led_reg;
    unique case (src_e'(disp_sel))
      SRC_LED:     src_word = led_reg;
      SRC_CYCLES:  src_word = total_cycles;
      SRC_CONDI:   src_word = condi_branch_num;
      SRC_UNCONDI: src_word = uncondi_branch_num;
      default:     src_word = led_reg;
    endcase
  end

  // Common-anode hex font, dp (bit 7) held off.
  always_comb begin
    seg_code = 8'hFF;
    unique case (nibble)
      4'h0: seg_code = 8'hC0;
      4'h1: seg_code = 8'hF9;
      4'h2: seg_code = 8'hA4;
      4'h3: seg_code = 8'hB0;
      4'h4: seg_code = 8'h99;
      4'h5: seg_code = 8'h92;
      4'h6: seg_code = 8'h82;
      4'h7: seg_code = 8'hF8;
      4'h8: seg_code = 8'h80;
      4'h9: seg_code = 8'h90;
      4'hA: seg_code = 8'h88;
      4'hB: seg_code = 8'h83;
      4'hC: seg_code = 8'hC6;
      4'hD: seg_code = 8'hA1;
      4'hE: seg_code = 8'h86;
      4'hF: seg_code = 8'h8E;
      default: seg_code = 8'hFF;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt   <= '0;
      digit_idx <= 3'd0;
    end else begin
      div_cnt <= scan_tick ? '0 : div_cnt + 1'b1;
      if (scan_tick) digit_idx <= digit_idx + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_reg <= '0;
    end else if (led_we) begin
      led_reg <= led_data_in;
    end
  end

  // Snapshot reads led_reg before this edge's write, so a coincident led_we shows next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snapshot   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_wrap;
      if (frame_wrap && !freeze) snapshot <= src_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_out  <= 8'hFF;
      seg_out <= 8'hFF;
    end else begin
      an_out  <= ~(8'b1 << digit_idx);
      seg_out <= seg_code;
    end
  end

endmodule

// File: tb/tb_led_display_ctrl.sv
// Scoreboard bench for led_display_ctrl: a cycle-count reference model queues the expected
// outputs for every clock edge and a negedge monitor compares them against the DUT.
module tb_led_display_ctrl;

  localparam int SD    = 4;
  localparam int FRAME = 8 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        led_we = 1'b0;
  logic [31:0] led_data_in = '0;
  logic [31:0] total_cycles = '0;
  logic [31:0] condi_branch_num = '0;
  logic [31:0] uncondi_branch_num = '0;
  logic [1:0]  disp_sel = 2'd0;
  logic        freeze = 1'b0;
  logic [7:0]  an_out;
  logic [7:0]  seg_out;
  logic        frame_done;

  led_display_ctrl #(.SCAN_DIV(SD)) dut (
    .clk                (clk),
    .rst                (rst),
    .led_we             (led_we),
    .led_data_in        (led_data_in),
    .total_cycles       (total_cycles),
    .condi_branch_num   (condi_branch_num),
    .uncondi_branch_num (uncondi_branch_num),
    .disp_sel           (disp_sel),
    .freeze             (freeze),
    .an_out             (an_out),
    .seg_out            (seg_out),
    .frame_done         (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seg;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: everything follows from the number of edges since reset release.
  int          m_t = 0;
  logic [31:0] m_led = '0;
  logic [31:0] m_snap = '0;
  int          m_digit;
  logic        m_wrap;
  logic [31:0] m_src;
  exp_t        m_exp;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_t    = 0;
        m_led  = '0;
        m_snap = '0;
        exp_q.delete();
      end else begin
        m_digit = (m_t / SD) % 8;
        m_wrap  = (m_t % FRAME) == FRAME - 1;
        m_exp.an  = ~(8'd1 << m_digit);
        m_exp.seg = hex_tab[m_snap[m_digit*4 +: 4]];
        m_exp.fd  = m_wrap;
        case (disp_sel)
          2'd0:    m_src = m_led;
          2'd1:    m_src = total_cycles;
          2'd2:    m_src = condi_branch_num;
          default: m_src = uncondi_branch_num;
        endcase
        if (m_wrap && !freeze) m_snap = m_src;
        if (led_we) m_led = led_data_in;
        m_t++;
        exp_q.push_back(m_exp);
      end
    end
  end

  // Monitor: outputs change only on posedge or on rst falling, so negedge is a stable sample point.
  exp_t got_exp;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("reset an_out", {24'd0, an_out}, 32'hFF);
        check("reset seg_out", {24'd0, seg_out}, 32'hFF);
        check("reset frame_done", {31'd0, frame_done}, 32'd0);
      end else if (exp_q.size() == 0) begin
        check("scoreboard empty", 32'd1, 32'd0);
      end else begin
        got_exp = exp_q.pop_front();
        check("an_out", {24'd0, an_out}, {24'd0, got_exp.an});
        check("seg_out", {24'd0, seg_out}, {24'd0, got_exp.seg});
        check("frame_done", {31'd0, frame_done}, {31'd0, got_exp.fd});
        check("one digit lit", ($countones(~an_out) <= 1) ? 32'd1 : 32'd0, 32'd1);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_we(input logic [31:0] data);
    led_data_in = data;
    led_we = 1'b1;
    step(1);
    led_we = 1'b0;
  endtask

  // Leaves the bench so that the next posedge is a frame-wrap edge.
  task automatic to_wrap();
    int guard = 0;
    while ((m_t % FRAME) != FRAME - 1 && guard < 2 * FRAME) begin
      step(1);
      guard++;
    end
    check("reach wrap", (guard < 2 * FRAME) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic async_reset(input int hold);
    rst = 1'b0;
    #1;
    check("async an_out", {24'd0, an_out}, 32'hFF);
    check("async seg_out", {24'd0, seg_out}, 32'hFF);
    check("async frame_done", {31'd0, frame_done}, 32'd0);
    step(hold);
    rst = 1'b1;
  endtask

  initial begin
    int guard;
    step(3);
    rst = 1'b1;

    // Scan from reset, then a mid-frame write that must wait for the wrap.
    step(40);
    pulse_we(32'h89AB_CDEF);
    step(2 * FRAME);

    // Cycle counter source, then a mid-frame source switch.
    total_cycles = 32'h0000_0123;
    disp_sel = 2'd1;
    to_wrap();
    step(12);
    condi_branch_num = 32'h5555_AAAA;
    disp_sel = 2'd2;
    step(FRAME + 8);

    // Frozen snapshot across a wrap while led_reg changes.
    disp_sel = 2'd0;
    to_wrap();
    step(4);
    freeze = 1'b1;
    pulse_we(32'h0F1E_2D3C);
    to_wrap();
    step(FRAME);
    freeze = 1'b0;

    // Write coinciding with a wrap edge.
    pulse_we(32'h1111_1111);
    to_wrap();
    step(1);
    to_wrap();
    pulse_we(32'h2222_2222);
    step(2 * FRAME);

    // Reset in the middle of digit 5.
    guard = 0;
    while (((m_t / SD) % 8) != 5 && guard < 2 * FRAME) begin
      step(1);
      guard++;
    end
    step(1);
    async_reset(2);
    step(FRAME + 4);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      total_cycles       = $urandom;
      condi_branch_num   = $urandom;
      uncondi_branch_num = $urandom;
      if ($urandom_range(0, 15) == 0) disp_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) freeze = ~freeze;
      led_data_in = $urandom;
      led_we = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 399) == 0) async_reset(1 + $urandom_range(0, 2));
      else step(1);
    end
    led_we = 1'b0;
    step(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
